// File: rtl/irq_ctrl.sv
// Vectored interrupt controller: per-channel edge/level capture, IO-mapped
// enable/pending/status/force registers, fixed or round-robin priority, req/ack/done handshake.
module irq_ctrl #(
  parameter int unsigned NUM_IRQ    = 4,
  parameter logic [7:0]  EDGE_MASK  = 8'h0F,
  parameter logic [15:0] VEC_BASE   = 16'h0004,
  parameter int unsigned VEC_STRIDE = 2,
  parameter bit          RR_EN      = 1'b0,
  parameter logic [7:0]  IO_BASE    = 8'h20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic [NUM_IRQ-1:0] irq_clr,
  input  logic [7:0]         io_addr,
  input  logic [7:0]         io_wdata,
  input  logic               io_we,
  output logic [7:0]         io_rdata,
  input  logic               gie,
  output logic               irq_req,
  output logic [15:0]        irq_vector,
  input  logic               irq_ack,
  input  logic               irq_done
);

  localparam int unsigned IDX_W = 3;
  localparam int unsigned VEC_W = 16;
  localparam int unsigned IO_W  = 8;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] SERVICE = 2'd2;

  localparam logic [NUM_IRQ-1:0] EDGE_SEL = EDGE_MASK[NUM_IRQ-1:0];

  logic [1:0]         state, stateNext;
  logic [NUM_IRQ-1:0] pending, pendingNext;
  logic [NUM_IRQ-1:0] enable, enableNext;
  logic [NUM_IRQ-1:0] irqPrev;
  logic [IDX_W-1:0]   activeIdx, activeIdxNext;
  logic [IDX_W-1:0]   rrPtr, rrPtrNext;
  logic               reqNext;
  logic [VEC_W-1:0]   vectorNext;
  logic [NUM_IRQ-1:0] clrNext;

  logic [NUM_IRQ-1:0] captureSet, swClear, swForce, ackMask, candidates;
  logic [IDX_W-1:0]   winIdx;
  logic               winFound;
  logic               selEnable, selPending, selStatus, selForce, busy;
  int                 arbPos;
  logic               unusedSink;

  assign unusedSink = ^{io_wdata, rrPtr};

  // Register window decode
  assign selEnable  = (io_addr == IO_BASE);
  assign selPending = (io_addr == IO_W'(IO_BASE + 8'd1));
  assign selStatus  = (io_addr == IO_W'(IO_BASE + 8'd2));
  assign selForce   = (io_addr == IO_W'(IO_BASE + 8'd3));

  assign busy       = (state == SERVICE);
  assign candidates = pending & enable;

  // Edge channels fire on 0->1 of the line, level channels whenever the line is high
  assign captureSet = irq_in & (~EDGE_SEL | ~irqPrev);
  assign swClear    = (io_we && selPending) ? io_wdata[NUM_IRQ-1:0] : '0;
  assign swForce    = (io_we && selForce)   ? io_wdata[NUM_IRQ-1:0] : '0;

  always_comb begin
    io_rdata = '0;
    if (selEnable)       io_rdata = IO_W'(enable);
    else if (selPending) io_rdata = IO_W'(pending);
    else if (selStatus)  io_rdata = {busy, 4'b0000, activeIdx};
  end

  // Winner search starts at rrPtr (round-robin) or at channel 0 (fixed)
  always_comb begin
    winFound = 1'b0;
    winIdx   = '0;
    arbPos   = 0;
    for (int k = 0; k < int'(NUM_IRQ); k++) begin
      arbPos = (RR_EN ? int'(rrPtr) : 0) + k;
      if (arbPos >= int'(NUM_IRQ)) arbPos = arbPos - int'(NUM_IRQ);
      for (int j = 0; j < int'(NUM_IRQ); j++) begin
        if (!winFound && candidates[j] && (arbPos == j)) begin
          winFound = 1'b1;
          winIdx   = IDX_W'(j);
        end
      end
    end
  end

  always_comb begin
    stateNext     = state;
    activeIdxNext = activeIdx;
    rrPtrNext     = rrPtr;
    reqNext       = irq_req;
    vectorNext    = irq_vector;
    clrNext       = '0;
    ackMask       = '0;
    enableNext    = (io_we && selEnable) ? io_wdata[NUM_IRQ-1:0] : enable;
    case (state)
      IDLE: begin
        if (gie && winFound) begin
          stateNext     = REQ;
          activeIdxNext = winIdx;
          reqNext       = 1'b1;
          vectorNext    = VEC_BASE + VEC_W'(VEC_STRIDE) * VEC_W'(winIdx);
        end
      end
      REQ: begin
        if (irq_ack) begin
          for (int i = 0; i < int'(NUM_IRQ); i++) begin
            if (activeIdx == IDX_W'(i)) ackMask[i] = 1'b1;
          end
          clrNext   = ackMask;
          rrPtrNext = (activeIdx == IDX_W'(NUM_IRQ - 1)) ? '0 : activeIdx + IDX_W'(1);
          reqNext   = 1'b0;
          stateNext = SERVICE;
        end
      end
      SERVICE: begin
        if (irq_done) stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
        reqNext   = 1'b0;
      end
    endcase
    // New captures and forces win over software and acknowledge clears
    pendingNext = (pending & ~swClear & ~ackMask) | captureSet | swForce;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending    <= '0;
      enable     <= '0;
      irqPrev    <= '0;
      activeIdx  <= '0;
      rrPtr      <= '0;
      irq_req    <= 1'b0;
      irq_vector <= '0;
      irq_clr    <= '0;
    end else begin
      pending    <= pendingNext;
      enable     <= enableNext;
      irqPrev    <= irq_in;
      activeIdx  <= activeIdxNext;
      rrPtr      <= rrPtrNext;
      irq_req    <= reqNext;
      irq_vector <= vectorNext;
      irq_clr    <= clrNext;
    end
  end

endmodule
